// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 complex butterfly (A + W*B, A - W*B) with valid/ready flow control.
// Optional macro BUTTERFLY_PIPE_SAT_EN: saturate overflowing components instead of wrapping them.
module butterfly_pipe #(
    parameter int WORD_SZ   = 32,
    parameter int FRAC_BITS = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [WORD_SZ-1:0] i_A,
    input  logic [WORD_SZ-1:0] i_B,
    input  logic [WORD_SZ-1:0] i_twiddle,
    input  logic               i_scale,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [WORD_SZ-1:0] o_A,
    output logic [WORD_SZ-1:0] o_B,
    output logic               o_valid,
    input  logic               i_ready,
    input  logic               i_clr_ovf,
    output logic               o_ovf
);
    localparam int WORD_MID = WORD_SZ / 2;
    localparam int PW = 2 * WORD_MID;
    localparam int SW = 2 * WORD_MID + 2;

    logic en;
    logic s1_valid, s1_scale;
    logic [WORD_SZ-1:0] s1_a, s1_b, s1_w;
    logic s2_valid, s2_scale;
    logic [WORD_SZ-1:0] s2_a;
    logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
    logic signed [PW-1:0] br, bi, wr, wi;
    logic signed [SW-1:0] a_re, a_im, wb_re, wb_im;
    logic signed [SW-1:0] sum [4];
    logic signed [SW-1:0] res [4];
    logic [3:0] ovf;
    logic [WORD_MID-1:0] q [4];

    // The whole pipeline moves as one unit whenever the output slot is free or being drained.
    assign en = !o_valid || i_ready;
    assign o_ready = en || !i_rst_n;

    // Operand halves sign-extended so the products keep full precision.
    assign br = PW'($signed(s1_b[WORD_SZ-1:WORD_MID]));
    assign bi = PW'($signed(s1_b[WORD_MID-1:0]));
    assign wr = PW'($signed(s1_w[WORD_SZ-1:WORD_MID]));
    assign wi = PW'($signed(s1_w[WORD_MID-1:0]));

    // Twiddled bottom input, A widened, then butterfly sums with optional halving and width reduction.
    always_comb begin
        wb_re = (SW'(s2_rr) - SW'(s2_ii)) >>> FRAC_BITS;
        wb_im = (SW'(s2_ri) + SW'(s2_ir)) >>> FRAC_BITS;
        a_re = SW'($signed(s2_a[WORD_SZ-1:WORD_MID]));
        a_im = SW'($signed(s2_a[WORD_MID-1:0]));
        sum[0] = a_re + wb_re;
        sum[1] = a_im + wb_im;
        sum[2] = a_re - wb_re;
        sum[3] = a_im - wb_im;
        for (int k = 0; k < 4; k++) begin
            res[k] = s2_scale ? sum[k] >>> 1 : sum[k];
            ovf[k] = !(&res[k][SW-1:WORD_MID-1] || !(|res[k][SW-1:WORD_MID-1]));
`ifdef BUTTERFLY_PIPE_SAT_EN
            q[k] = ovf[k] ? {res[k][SW-1], {(WORD_MID-1){!res[k][SW-1]}}} : res[k][WORD_MID-1:0];
`else
            q[k] = res[k][WORD_MID-1:0];
`endif
        end
    end

    // Three pipeline stages: input capture, products, sums to the output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_scale <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_w     <= '0;
            s2_valid <= 1'b0;
            s2_scale <= 1'b0;
            s2_a     <= '0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_ri    <= '0;
            s2_ir    <= '0;
            o_valid  <= 1'b0;
            o_A      <= '0;
            o_B      <= '0;
        end else if (en) begin
            s1_valid <= i_valid;
            s1_scale <= i_scale;
            s1_a     <= i_A;
            s1_b     <= i_B;
            s1_w     <= i_twiddle;
            s2_valid <= s1_valid;
            s2_scale <= s1_scale;
            s2_a     <= s1_a;
            s2_rr    <= br * wr;
            s2_ii    <= bi * wi;
            s2_ri    <= br * wi;
            s2_ir    <= bi * wr;
            o_valid  <= s2_valid;
            o_A      <= {q[0], q[1]};
            o_B      <= {q[2], q[3]};
        end
    end

    // Sticky overflow: a valid overflowing result entering the output stage beats a clear request.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_ovf <= 1'b0;
        else if (en && s2_valid && |ovf)
            o_ovf <= 1'b1;
        else if (i_clr_ovf)
            o_ovf <= 1'b0;
    end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: scoreboard bench for butterfly_pipe, random traffic checked against an arithmetic model.
module tb_butterfly_pipe;
    localparam int W = 32;
    localparam int H = 16;

    logic clk = 1'b0;
    logic rst_n, i_scale, i_valid, o_ready, o_valid, i_ready, i_clr_ovf, o_ovf;
    logic [W-1:0] i_A, i_B, i_twiddle, o_A, o_B;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    logic exp_ovf = 1'b0;
    int stall = 0;
    logic rand_rdy = 1'b0;
    logic rst_at_edge;

    butterfly_pipe dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_A(i_A), .i_B(i_B), .i_twiddle(i_twiddle),
        .i_scale(i_scale), .i_valid(i_valid), .o_ready(o_ready), .o_A(o_A), .o_B(o_B),
        .o_valid(o_valid), .i_ready(i_ready), .i_clr_ovf(i_clr_ovf), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    // Remembers whether the last edge was a reset edge, so hold checks skip it.
    always @(posedge clk) rst_at_edge <= !rst_n;

    // Complex butterfly in plain integer arithmetic on Q9.6 halves.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] w, input logic s);
        longint ar, ai, br, bi, wr, wi, wbr, wbi;
        longint v[4];
        logic [H-1:0] r[4];
        logic [3:0] ov;
        exp_t e;
        ar = longint'($signed(a[W-1:H]));
        ai = longint'($signed(a[H-1:0]));
        br = longint'($signed(b[W-1:H]));
        bi = longint'($signed(b[H-1:0]));
        wr = longint'($signed(w[W-1:H]));
        wi = longint'($signed(w[H-1:0]));
        wbr = (br * wr - bi * wi) >>> 6;
        wbi = (br * wi + bi * wr) >>> 6;
        v[0] = ar + wbr;
        v[1] = ai + wbi;
        v[2] = ar - wbr;
        v[3] = ai - wbi;
        for (int k = 0; k < 4; k++) begin
            if (s) v[k] = v[k] >>> 1;
            ov[k] = (v[k] > 32767) || (v[k] < -32768);
`ifdef BUTTERFLY_PIPE_SAT_EN
            r[k] = (v[k] > 32767) ? 16'h7FFF : (v[k] < -32768) ? 16'h8000 : v[k][H-1:0];
`else
            r[k] = v[k][H-1:0];
`endif
        end
        e.a = {r[0], r[1]};
        e.b = {r[2], r[3]};
        e.ovf = |ov;
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] x;
        x = $urandom;
        if ($urandom_range(0, 1) == 1)
            x = {{6{x[25]}}, x[25:16], {6{x[9]}}, x[9:0]};
        return x;
    endfunction

    // Present one transaction, hold it until accepted, then record its expected result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] w, input logic s);
        int n = 0;
        i_A = a;
        i_B = b;
        i_twiddle = w;
        i_scale = s;
        i_valid = 1'b1;
        @(negedge clk);
        while (!o_ready) begin
            n++;
            if (n > 200) begin
                $display("FAIL send_timeout: o_ready stuck at %b expected 1", o_ready);
                $fatal(1);
            end
            @(negedge clk);
        end
        sb.push_back(model(a, b, w, s));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Single transaction into an empty pipeline with known constant results and exact latency.
    task automatic dir(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] w,
                       input logic s, input logic [W-1:0] ea, input logic [W-1:0] eb, input logic eovf);
        send(a, b, w, s);
        @(negedge clk);
        chk({nm, "_lat1"}, o_valid, 0);
        @(negedge clk);
        chk({nm, "_lat2"}, o_valid, 0);
        @(negedge clk);
        chk({nm, "_valid"}, o_valid, 1);
        chk({nm, "_A"}, o_A, ea);
        chk({nm, "_B"}, o_B, eb);
        chk({nm, "_ovf"}, o_ovf, eovf);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_left", sb.size(), 0);
    endtask

    // Downstream sink: forced stall windows, otherwise random or always ready.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall > 0) begin
                i_ready = 1'b0;
                stall--;
            end else begin
                i_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard at every hand-off and checks hold behaviour during stalls.
    initial begin
        logic ph;
        logic [W-1:0] pa, pb;
        exp_t e;
        ph = 1'b0;
        pa = '0;
        pb = '0;
        forever begin
            @(negedge clk);
            if (ph && !rst_at_edge) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_A", o_A, pa);
                chk("hold_B", o_B, pb);
            end
            chk("o_ready", o_ready, rst_n ? (!o_valid || i_ready) : 1'b1);
            if (o_valid && i_ready && rst_n) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got A=%h B=%h expected no output", o_A, o_B);
                end else begin
                    e = sb.pop_front();
                    exp_ovf = exp_ovf | e.ovf;
                    chk("sb_A", o_A, e.a);
                    chk("sb_B", o_B, e.b);
                    chk("sb_ovf", o_ovf, exp_ovf);
                end
            end
            ph = o_valid && !i_ready && rst_n;
            pa = o_A;
            pb = o_B;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ea, eb, va, vw;
        va = 32'h0040_0080;
        vw = 32'h00C0_0100;
`ifdef BUTTERFLY_PIPE_SAT_EN
        ea = 32'h7FFF_0000;
`else
        ea = 32'hFF80_0000;
`endif
        eb = 32'h0000_0000;
        rst_n = 1'b0;
        i_A = '0;
        i_B = '0;
        i_twiddle = '0;
        i_scale = 1'b0;
        i_valid = 1'b0;
        i_clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_A", o_A, 0);
        chk("rst_B", o_B, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_ready", o_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        dir("basic", va, vw, 32'h0040_0000, 1'b0, 32'h0100_0180, 32'hFF80_FF80, 1'b0);
        dir("rot", va, vw, 32'h0000_FFC0, 1'b0, 32'h0140_FFC0, 32'hFF40_0140, 1'b0);
        dir("scale", va, vw, 32'h0040_0000, 1'b1, 32'h0080_00C0, 32'hFFC0_FFC0, 1'b0);
        dir("ovf", 32'h7FC0_0000, 32'h7FC0_0000, 32'h0040_0000, 1'b0, ea, eb, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ovf_sticky", o_ovf, 1);
        @(posedge clk);
        #1;
        i_clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        i_clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", o_ovf, 0);
        @(posedge clk);
        #1;
        i_clr_ovf = 1'b1;
        dir("set_wins", 32'h7FC0_0000, 32'h7FC0_0000, 32'h0040_0000, 1'b0, ea, eb, 1'b1);
        i_clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        chk("clr_after_set", o_ovf, 0);

        @(negedge clk);
        stall = 5;
        @(posedge clk);
        #1;
        repeat (3) send(rnd_word(), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
        @(negedge clk);
        chk("bp_ready_low", o_ready, 0);
        send(rnd_word(), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
        drain();

        rand_rdy = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                send(rnd_word(), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
            end
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(rnd_word(), rnd_word(), rnd_word(), 1'b0);
        send(rnd_word(), rnd_word(), rnd_word(), 1'b0);
        rst_n = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_A", o_A, 0);
        chk("midrst_B", o_B, 0);
        chk("midrst_ovf", o_ovf, 0);
        repeat (10) @(posedge clk);
        #1;
        dir("after_rst", va, vw, 32'h0040_0000, 1'b0, 32'h0100_0180, 32'hFF80_FF80, 1'b0);

        rand_rdy = 1'b1;
        repeat (100) send(rnd_word(), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
